// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - instruction sequencer: fetch/decode/execute FSM driving PC, memory and ALU strobes
module pc_sequencer #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [2:0] pc,
  output logic       mem_req,
  output logic [2:0] mem_addr,
  input  logic       mem_ack,
  input  logic [4:0] mem_rdata,
  output logic       pc_inc,
  output logic       pc_load,
  output logic [2:0] pc_load_val,
  output logic       alu_en,
  output logic [2:0] alu_op,
  output logic       reg_we,
  output logic       busy,
  output logic       halted,
  output logic       fault,
  output logic [7:0] retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_ALU = 2'd1;
  localparam logic [1:0] OP_JMP = 2'd2;
  localparam logic [1:0] OP_HLT = 2'd3;

  // Wait count compared before increment, so the fault edge lands ACK_TIMEOUT cycles after FETCH entry
  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  logic [2:0] r_state;
  logic [4:0] r_ir;
  logic       r_stop;
  logic [7:0] r_wait;
  logic [7:0] r_retired;
  logic       r_mem_req;
  logic       r_pc_inc;
  logic       r_pc_load;
  logic [2:0] r_pc_load_val;
  logic       r_alu_en;
  logic [2:0] r_alu_op;
  logic       r_reg_we;
  logic       r_busy;
  logic       r_halted;
  logic       r_fault;

  logic [2:0] w_next_state;
  logic [1:0] w_op;
  logic       w_boundary;
  logic       w_timeout;
  logic       w_retire;
  logic       w_busy_state;

  assign w_op         = r_ir[4:3];
  assign w_busy_state = (r_state != S_IDLE) && (r_state != S_HALT);
  assign w_retire     = w_boundary || ((r_state == S_EXEC) && (w_op == OP_HLT));

  // Next-state selection; a stop seen this cycle counts as pending at the boundary
  always_comb begin
    w_next_state = r_state;
    w_boundary   = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) w_next_state = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack) begin
          w_next_state = S_DECODE;
        end else if (r_wait == TIMEOUT_LAST) begin
          w_next_state = S_HALT;
          w_timeout    = 1'b1;
        end
      end
      S_DECODE: w_next_state = S_EXEC;
      S_EXEC: begin
        case (w_op)
          OP_ALU:  w_next_state = S_WB;
          OP_HLT:  w_next_state = S_HALT;
          default: w_boundary   = 1'b1;
        endcase
      end
      S_WB:    w_boundary   = 1'b1;
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_IDLE;
    endcase
    if (w_boundary) w_next_state = (r_stop || stop) ? S_IDLE : S_FETCH;
  end

  // State, instruction register, stop flag, ack wait counter and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ir      <= 5'd0;
      r_stop    <= 1'b0;
      r_wait    <= 8'd0;
      r_retired <= 8'd0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == S_FETCH) && mem_ack) r_ir <= mem_rdata;
      if ((r_state == S_FETCH) && (w_next_state == S_FETCH)) r_wait <= r_wait + 8'd1;
      else r_wait <= 8'd0;
      if (w_boundary && (w_next_state == S_IDLE)) r_stop <= 1'b0;
      else if (w_busy_state && stop) r_stop <= 1'b1;
      if (w_retire && (r_retired != 8'hFF)) r_retired <= r_retired + 8'd1;
    end
  end

  // Registered strobes decoded from the state being entered, so each is high exactly while in that state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_req     <= 1'b0;
      r_pc_inc      <= 1'b0;
      r_pc_load     <= 1'b0;
      r_pc_load_val <= 3'd0;
      r_alu_en      <= 1'b0;
      r_alu_op      <= 3'd0;
      r_reg_we      <= 1'b0;
      r_busy        <= 1'b0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_mem_req     <= (w_next_state == S_FETCH);
      r_pc_inc      <= ((w_next_state == S_EXEC) && (w_op == OP_NOP)) || (w_next_state == S_WB);
      r_pc_load     <= (w_next_state == S_EXEC) && (w_op == OP_JMP);
      r_pc_load_val <= ((w_next_state == S_EXEC) && (w_op == OP_JMP)) ? r_ir[2:0] : 3'd0;
      r_alu_en      <= (w_next_state == S_EXEC) && (w_op == OP_ALU);
      r_alu_op      <= (((w_next_state == S_EXEC) && (w_op == OP_ALU)) || (w_next_state == S_WB))
                       ? r_ir[2:0] : 3'd0;
      r_reg_we      <= (w_next_state == S_WB);
      r_busy        <= (w_next_state != S_IDLE) && (w_next_state != S_HALT);
      r_halted      <= (w_next_state == S_HALT);
      r_fault       <= r_fault || w_timeout;
    end
  end

  // Address follows the live pc so it reflects an update made on the FETCH entry edge
  assign mem_addr    = r_mem_req ? pc : 3'd0;
  assign mem_req     = r_mem_req;
  assign pc_inc      = r_pc_inc;
  assign pc_load     = r_pc_load;
  assign pc_load_val = r_pc_load_val;
  assign alu_en      = r_alu_en;
  assign alu_op      = r_alu_op;
  assign reg_we      = r_reg_we;
  assign busy        = r_busy;
  assign halted      = r_halted;
  assign fault       = r_fault;
  assign retired     = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic [2:0] pc;
  logic       mem_req;
  logic [2:0] mem_addr;
  logic       mem_ack;
  logic [4:0] mem_rdata;
  logic       pc_inc;
  logic       pc_load;
  logic [2:0] pc_load_val;
  logic       alu_en;
  logic [2:0] alu_op;
  logic       reg_we;
  logic       busy;
  logic       halted;
  logic       fault;
  logic [7:0] retired;

  logic [4:0] mem [8];
  logic       set_pc_en;
  logic [2:0] set_pc_val;
  logic       ack_en;
  logic       force_ack;
  int         ack_delay;
  int         req_cnt;
  int         stop_cyc;
  int         fack_cyc;
  int         ack_off_cyc;
  int         addr_lo_cyc;
  logic [2:0] addr_lo;
  logic [2:0] addr_hi;

  int n_checks = 0;
  int n_errors = 0;
  int n_conflict = 0;
  int n_bad_addr;

  logic [31:0] v_req, v_inc, v_load, v_alu, v_we, v_halt, v_fault, v_busy;
  logic [2:0]  cap_op_exec, cap_op_wb, cap_load_val;

  pc_sequencer #(.ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pc(pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .pc_inc(pc_inc), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .alu_en(alu_en), .alu_op(alu_op), .reg_we(reg_we),
    .busy(busy), .halted(halted), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = force_ack | (mem_req & ack_en & (req_cnt >= ack_delay));

  // Program counter and memory-latency model
  always @(posedge clk) begin
    if (set_pc_en) pc <= set_pc_val;
    else if (pc_load) pc <= pc_load_val;
    else if (pc_inc) pc <= pc + 3'd1;
    req_cnt <= mem_req ? req_cnt + 1 : 0;
  end

  // Strobe exclusivity monitor
  always @(negedge clk) begin
    if (pc_inc && pc_load) n_conflict <= n_conflict + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit load_pc, input logic [2:0] pcv);
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    set_pc_en = load_pc; set_pc_val = pcv;
    ack_en = 1'b1; ack_delay = 0; force_ack = 1'b0;
    stop_cyc = 0; fack_cyc = 0; ack_off_cyc = 1000000; addr_lo_cyc = 0;
    tick();
    rst = 1'b0; set_pc_en = 1'b0;
  endtask

  // Runs n cycles starting at the edge that samples start; bit c of each vector is cycle c
  task automatic run(input int n);
    v_req = 0; v_inc = 0; v_load = 0; v_alu = 0; v_we = 0; v_halt = 0; v_fault = 0; v_busy = 0;
    cap_op_exec = 0; cap_op_wb = 0; cap_load_val = 0; n_bad_addr = 0;
    for (int c = 1; c <= n; c++) begin
      tick();
      start = 1'b0;
      stop = (c == stop_cyc);
      force_ack = (c == fack_cyc);
      if (c >= ack_off_cyc) ack_en = 1'b0;
      if (c < 32) begin
        v_req[c] = mem_req; v_inc[c] = pc_inc; v_load[c] = pc_load; v_alu[c] = alu_en;
        v_we[c] = reg_we; v_halt[c] = halted; v_fault[c] = fault; v_busy[c] = busy;
      end
      if (alu_en) cap_op_exec = alu_op;
      if (reg_we) cap_op_wb = alu_op;
      if (pc_load) cap_load_val = pc_load_val;
      if (addr_lo_cyc != 0 && mem_req && mem_addr != ((c <= addr_lo_cyc) ? addr_lo : addr_hi))
        n_bad_addr++;
    end
  endtask

  function automatic logic [31:0] outs();
    return {7'd0, mem_req, mem_addr, pc_inc, pc_load, pc_load_val, alu_en, alu_op,
            reg_we, busy, halted, fault, retired};
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 5'd0;
    req_cnt = 0;
    pc = 3'd0;
    rst = 1'b1; start = 1'b1; stop = 1'b0; set_pc_en = 1'b0; set_pc_val = 3'd0;
    ack_en = 1'b1; ack_delay = 0; force_ack = 1'b0;
    tick(); tick();
    chk("reset_outputs", outs(), 32'd0);

    // Straight line: NOP, ALU op5, NOP, HLT
    mem[0] = 5'b00_000; mem[1] = 5'b01_101; mem[2] = 5'b00_000; mem[3] = 5'b11_000;
    do_reset(1'b1, 3'd0);
    start = 1'b1;
    run(15);
    chk("line_pc_inc", v_inc, 32'h0000_0488);
    chk("line_mem_req", v_req, 32'h0000_0912);
    chk("line_alu_en", v_alu, 32'h0000_0040);
    chk("line_reg_we", v_we, 32'h0000_0080);
    chk("line_alu_op_exec", {29'd0, cap_op_exec}, 32'd5);
    chk("line_alu_op_wb", {29'd0, cap_op_wb}, 32'd5);
    chk("line_halted", v_halt, 32'h0000_C000);
    chk("line_retired", {24'd0, retired}, 32'd4);
    chk("line_fault", {31'd0, fault}, 32'd0);

    // Reset during WB of an ALU, then restart from the incremented pc
    do_reset(1'b1, 3'd1);
    start = 1'b1;
    run(4);
    chk("midalu_in_wb", {31'd0, reg_we}, 32'd1);
    rst = 1'b1;
    tick();
    chk("midalu_reset_outputs", outs(), 32'd0);
    rst = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("midalu_refetch", {28'd0, mem_req, mem_addr}, 32'h0000_000A);

    // Jump and wrap: pc7 NOP -> pc0 JMP 6 -> pc6 HLT
    mem[7] = 5'b00_000; mem[0] = 5'b10_110; mem[6] = 5'b11_000;
    do_reset(1'b1, 3'd7);
    start = 1'b1;
    run(11);
    chk("jmp_pc_inc", v_inc, 32'h0000_0008);
    chk("jmp_pc_load", v_load, 32'h0000_0040);
    chk("jmp_load_val", {29'd0, cap_load_val}, 32'd6);
    chk("jmp_halted", v_halt, 32'h0000_0C00);
    chk("jmp_retired", {24'd0, retired}, 32'd3);
    chk("jmp_pc_final", {29'd0, pc}, 32'd6);

    // Stalled NOP at pc3, stray ack in DECODE, then timeout on the next fetch
    mem[3] = 5'b00_000; mem[0] = 5'b11_000;
    do_reset(1'b1, 3'd3);
    ack_delay = 4; fack_cyc = 6; ack_off_cyc = 7;
    addr_lo_cyc = 5; addr_lo = 3'd3; addr_hi = 3'd4;
    start = 1'b1;
    run(24);
    chk("stall_mem_req", v_req, 32'h007F_FF3E);
    chk("stall_addr_stable", n_bad_addr, 32'd0);
    chk("stall_pc_inc", v_inc, 32'h0000_0080);
    chk("timeout_halted", v_halt, 32'h0180_0000);
    chk("timeout_fault", v_fault, 32'h0180_0000);
    chk("timeout_retired", {24'd0, retired}, 32'd1);
    start = 1'b1; stop = 1'b1;
    tick(); tick(); tick();
    start = 1'b0; stop = 1'b0;
    chk("halt_absorbing", {28'd0, mem_req, busy, halted, fault}, 32'h0000_0003);

    // Stop pulsed in DECODE of an ALU
    mem[1] = 5'b01_011; mem[2] = 5'b00_000;
    do_reset(1'b1, 3'd1);
    stop_cyc = 2;
    start = 1'b1;
    run(6);
    chk("stop_reg_we", v_we, 32'h0000_0010);
    chk("stop_pc_inc", v_inc, 32'h0000_0010);
    chk("stop_mem_req", v_req, 32'h0000_0002);
    chk("stop_busy", v_busy, 32'h0000_001E);
    chk("stop_retired", {24'd0, retired}, 32'd1);

    // Start together with stop in IDLE is ignored
    start = 1'b1; stop = 1'b1;
    tick(); tick();
    start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", {30'd0, busy, mem_req}, 32'd0);

    // Looping JMP 0: retire count saturates
    mem[0] = 5'b10_000;
    do_reset(1'b1, 3'd0);
    start = 1'b1;
    run(301);
    chk("loop_retired_100", {24'd0, retired}, 32'd100);
    run(600);
    chk("loop_retired_sat", {24'd0, retired}, 32'd255);
    chk("loop_busy", {31'd0, busy}, 32'd1);

    chk("strobe_exclusive", n_conflict, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
